// File: rtl/fir2d_coeff_ctrl.sv
// fir2d_coeff_ctrl: shadow/active 5x5 coefficient banks for fir2d, swapped only on a vs_i rising edge
module fir2d_coeff_ctrl #(
  parameter int NTAPS  = 25,
  parameter int CW     = 16,
  parameter int CENTER = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vs_i,
  input  logic                wr_en,
  input  logic [4:0]          wr_addr,
  input  logic [CW-1:0]       wr_data,
  input  logic                load_preset,
  input  logic [1:0]          preset_sel,
  input  logic                commit,
  output logic [NTAPS*CW-1:0] coeffs,
  output logic                busy,
  output logic                pending,
  output logic                applied,
  output logic                wr_err
);
  localparam logic [4:0] LAST = 5'(NTAPS - 1);
  typedef enum logic [1:0] {IDLE, FILL, ARMED, APPLY} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] shadow_q [NTAPS];
  logic [CW-1:0] shadow_d [NTAPS];
  logic [CW-1:0] active_q [NTAPS];
  logic [CW-1:0] active_d [NTAPS];
  logic [4:0]    cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic          cmt_q, cmt_d, err_q, err_d, vs_q, vs_rise;
  // Sharpen uses the four orthogonal neighbours of the centre tap in a 5-wide kernel
  function automatic logic [CW-1:0] preset_val(input logic [1:0] sel, input int k);
    int v;
    v = (sel == 2'd0) ? ((k == CENTER) ? 256 : 0) :
        (sel == 2'd1) ? ((k == CENTER) ? 16 : 10) :
        (sel == 2'd2) ? ((k == CENTER) ? 6144 : -256) :
        (k == CENTER) ? 512 :
        (k == CENTER - 5 || k == CENTER - 1 || k == CENTER + 1 || k == CENTER + 5) ? -64 : 0;
    return CW'(v);
  endfunction
  assign vs_rise = vs_i & ~vs_q;
  assign busy    = (state_q == FILL);
  assign pending = (state_q == ARMED) || (state_q == APPLY);
  assign applied = (state_q == APPLY);
  assign wr_err  = err_q;
  for (genvar i = 0; i < NTAPS; i++) begin : g_out
    assign coeffs[i*CW +: CW] = active_q[i];
  end
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    cmt_d    = cmt_q;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_preset) begin
          state_d = FILL;
          cnt_d   = '0;
          sel_d   = preset_sel;
          cmt_d   = commit;
          err_d   = wr_en;
        end else begin
          if (wr_en && wr_addr <= LAST) shadow_d[wr_addr] = wr_data;
          err_d   = wr_en && (wr_addr > LAST);
          state_d = commit ? ARMED : IDLE;
        end
      end
      FILL: begin
        shadow_d[cnt_q] = preset_val(sel_q, int'(cnt_q));
        cnt_d = cnt_q + 5'd1;
        cmt_d = cmt_q | commit;
        err_d = wr_en | load_preset;
        if (cnt_q == LAST) begin
          state_d = (cmt_q | commit) ? ARMED : IDLE;
          cmt_d   = 1'b0;
        end
      end
      ARMED: begin
        err_d   = wr_en | load_preset;
        state_d = vs_rise ? APPLY : ARMED;
      end
      APPLY: begin
        err_d    = wr_en | load_preset;
        active_d = shadow_q;
        state_d  = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      cmt_q   <= 1'b0;
      err_q   <= 1'b0;
      vs_q    <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= preset_val(2'd0, k);
        active_q[k] <= preset_val(2'd0, k);
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      cmt_q    <= cmt_d;
      err_q    <= err_d;
      vs_q     <= vs_i;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end
endmodule
